param_cmd_arbiter: RTL and testbench
====================================

# param_cmd_arbiter

Shares the single control-parameter decoder between several command sources (e.g. UART and Ethernet command parsers). It accepts 32-bit parameter words from `N_REQ` requesters with round-robin fairness and presents one word at a time to the decoder. It waits for the decoder's ack/nak/err verdict, or a timeout, and routes the verdict back to the requester that issued the word.

## Interface
- `N_REQ`, 2: number of requesters; legal range 2..8.
- `TIMEOUT_CYCLES`, 15: WAIT-state cycles without a verdict before the arbiter reports TIMEOUT; legal range 4..255.
- `GAP_CYCLES`, 2: idle cycles after every verdict before the next issue; minimum 2.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a word pending.
- `req_data`  in  N_REQ*32  word of requester i at bits [32*i+31 : 32*i].
- `req_ready`  out  N_REQ  one-hot; the word is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  N_REQ  one-hot, single-cycle verdict strobe to the issuing requester.
- `rsp_code`  out  2  verdict, valid with `rsp_valid`: 0 ACK, 1 NAK, 2 ERR, 3 TIMEOUT.
- `dec_data`  out  32  word presented to the decoder; held stable from ISSUE until the verdict.
- `dec_valid`  out  1  single-cycle strobe to the decoder.
- `dec_ack`, `dec_nak`, `dec_err`  in  1 each  decoder verdict lines.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- **IDLE**
  - `req_ready` is combinational: the round-robin grant is masked by `req_valid` and is nonzero only in IDLE.
  - On a transfer: latch `req_data[i]` into `dec_data`, latch the owner index, go to ISSUE.
- **ISSUE** (1 cycle): `dec_valid`=1, clear the timeout counter, then go to WAIT.
- **WAIT**
  - Sample `dec_err`, `dec_nak`, `dec_ack` each cycle.
  - If any is high: priority is err > nak > ack. Register `rsp_code`, pulse `rsp_valid[owner]` next cycle, go to GAP.
  - Otherwise increment the counter. When the count equals `TIMEOUT_CYCLES`: `rsp_code`=3, pulse `rsp_valid[owner]`, go to GAP.
- **GAP**: wait `GAP_CYCLES` cycles, then go to IDLE. This lets the decoder's 2-cycle ack and its late nak clear before the next issue.
- Verdict lines are ignored outside WAIT; stray pulses have no effect.
- Round-robin pointer:
  - After granting i, the search starts at (i+1) mod `N_REQ`.
  - The pointer does not move when there is no grant.
  - With all requesters valid, grants rotate 0,1,…,N_REQ-1,0.
- A requester deasserting `req_valid` before acceptance is legal; it receives no grant.
- `dec_data` keeps its last value outside a transaction.

## Timing
- Reset (async assert, sync deassert is the integrator's concern) forces:
  - all outputs 0: `req_ready`, `rsp_valid`, `rsp_code`, `dec_valid`, `dec_data`, `busy`;
  - state IDLE, pointer 0, counter 0.
- Reset mid-transaction drops that transaction; no `rsp_valid` is issued for it.
- Transfer in cycle t → `dec_valid` at t+1.
- With the standard decoder:
  - `dec_ack` is visible at t+3, giving `rsp_valid` at t+4.
  - `dec_nak` is visible at t+4, giving `rsp_valid` at t+5.
- Earliest next transfer after an ACK verdict: t+4+`GAP_CYCLES`.
- Throughput with the standard decoder and `GAP_CYCLES`=2: one word per 6 cycles (ACK), one per 7 cycles (NAK).
- A verdict and timeout in the same cycle: the verdict wins.

## Structure
- Shared package `param_cmd_pkg`:
  - response codes `RSP_ACK`, `RSP_NAK`, `RSP_ERR`, `RSP_TIMEOUT`;
  - state encoding.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector and an advance strobe;
  - outputs: a one-hot grant and its index;
  - owns the pointer register.
- The top level holds the FSM, data/owner latches, timeout counter and GAP counter.

## Test plan
- Single requester 0 sends 0x05_00ABCD; decoder model acks → `dec_valid` at t+1 with `dec_data`=0x0500ABCD, `rsp_valid`=01 at t+4, `rsp_code`=0, `busy` low again at t+6.
- Requesters 0 and 1 both continuously valid, 6 words each → grants alternate 0,1,0,1…; each gets exactly 6 `rsp_valid` strobes with its own verdicts.
- Decoder model returns nak (unknown code 0xFF) → `rsp_code`=1 at t+5; the next transfer is not accepted before t+7.
- Decoder model silent → after 15 WAIT cycles `rsp_code`=3 to the owner, then return to IDLE; a stray ack arriving during GAP is ignored.
- `dec_err` and `dec_ack` asserted together → `rsp_code`=2.
- `reset_n` pulled low during WAIT → all outputs 0 immediately; after release no `rsp_valid` for the dropped word, and the pointer restarts at requester 0.

Source files
------------

// File: rtl/param_cmd_pkg.sv
// Shared definitions for the parameter-command arbiter: verdict codes,
// FSM state encoding and the verdict priority helper.
package param_cmd_pkg;

    typedef enum logic [1:0] {
        RSP_ACK     = 2'd0,
        RSP_NAK     = 2'd1,
        RSP_ERR     = 2'd2,
        RSP_TIMEOUT = 2'd3
    } rsp_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Caller guarantees at least one verdict line is high; err beats nak beats ack.
    function automatic rsp_code_e verdict_code(input logic err, input logic nak);
        if (err) begin
            return RSP_ERR;
        end
        if (nak) begin
            return RSP_NAK;
        end
        return RSP_ACK;
    endfunction

endpackage

// File: rtl/param_cmd_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among active requests, searching from the
// slot after the last winner. The pointer only moves on an accepted grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx;
    logic          found;

    function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = slot(ptr_q, k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/param_cmd_arbiter.sv
// Shares one parameter decoder among N_REQ command sources: round-robin accept,
// single-cycle issue, verdict/timeout wait, then a guard gap before the next word.
module param_cmd_arbiter
    import param_cmd_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [1:0]            rsp_code,
    output logic [31:0]           dec_data,
    output logic                  dec_valid,
    input  logic                  dec_ack,
    input  logic                  dec_nak,
    input  logic                  dec_err,
    output logic                  busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES);

    state_e          state_q, state_d;
    logic [31:0]     data_q, data_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    rsp_code_e       rsp_code_q, rsp_code_d;

    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             accept;
    logic [31:0]      req_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_words[g] = req_data[32*g +: 32];
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Gated by reset_n as well so req_ready reads zero while reset is held.
    assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        owner_d     = owner_q;
        tmo_cnt_d   = tmo_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rsp_valid_d = '0;
        rsp_code_d  = rsp_code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = req_words[grant_idx];
                    owner_d = grant_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // A verdict in the final WAIT cycle is checked first, so it beats the timeout.
                if (dec_err || dec_nak || dec_ack) begin
                    rsp_code_d  = verdict_code(dec_err, dec_nak);
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    gap_cnt_d   = '0;
                    state_d     = ST_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    if (tmo_cnt_d == TW'(TIMEOUT_CYCLES)) begin
                        rsp_code_d  = RSP_TIMEOUT;
                        rsp_valid_d = N_REQ'(1) << owner_q;
                        gap_cnt_d   = '0;
                        state_d     = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            owner_q     <= '0;
            tmo_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= '0;
            rsp_code_q  <= RSP_ACK;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            owner_q     <= owner_d;
            tmo_cnt_q   <= tmo_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign dec_data  = data_q;
    assign dec_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_param_cmd_arbiter.sv
// Randomised bench for param_cmd_arbiter: a transaction-schedule model predicts
// grants, issue strobe, verdict timing/code and busy for every cycle.
module tb_param_cmd_arbiter;

    localparam int NR  = 2;
    localparam int TMO = 15;
    localparam int GAP = 2;

    localparam int MODE_STD    = 0;
    localparam int MODE_SILENT = 1;
    localparam int MODE_LATE   = 2;
    localparam int MODE_ERRACK = 3;
    localparam int MODE_RAND   = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*32-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [1:0]       rsp_code;
    logic [31:0]      dec_data;
    logic             dec_valid;
    logic             dec_ack = 1'b0;
    logic             dec_nak = 1'b0;
    logic             dec_err = 1'b0;
    logic             busy;

    always #5 clk = ~clk;

    param_cmd_arbiter #(
        .N_REQ          (NR),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_code  (rsp_code),
        .dec_data  (dec_data),
        .dec_valid (dec_valid),
        .dec_ack   (dec_ack),
        .dec_nak   (dec_nak),
        .dec_err   (dec_err),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level reference state.
    bit          act = 1'b0;
    int          t_iss, rsp_cyc, end_cyc, owner;
    int          ptr = 0;
    logic [31:0] last_data = '0;
    logic [1:0]  exp_code = 2'd0;
    int          plan_cyc = -100;
    logic [2:0]  plan_lines = 3'b000;   // {err, nak, ack}

    int          mode = MODE_STD;
    int          valid_pct = 100;
    bit          force_ff = 1'b0;
    int          remaining [NR];
    logic [31:0] cur_word [NR];
    int          rsp_cnt [NR];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        w = $urandom;
        if (force_ff) begin
            w[31:24] = 8'hFF;
        end else if (w[31:24] == 8'hFF) begin
            w[31:24] = 8'h01;
        end
        return w;
    endfunction

    function automatic logic [NR-1:0] rr_pick(input logic [NR-1:0] v);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (ptr + k) % NR;
            if (v[j]) begin
                return NR'(1) << j;
            end
        end
        return '0;
    endfunction

    function automatic int first_one(input logic [NR-1:0] g);
        for (int i = 0; i < NR; i++) begin
            if (g[i]) begin
                return i;
            end
        end
        return 0;
    endfunction

    task automatic start_txn(input int i);
        act       = 1'b1;
        t_iss     = cyc + 1;
        owner     = i;
        last_data = cur_word[i];
        ptr       = (i + 1) % NR;
        remaining[i]--;
        case (mode)
            MODE_STD: begin
                if (cur_word[i][31:24] == 8'hFF) begin
                    plan_lines = 3'b010;
                    plan_cyc   = t_iss + 3;
                end else begin
                    plan_lines = 3'b001;
                    plan_cyc   = t_iss + 2;
                end
            end
            MODE_SILENT: begin
                plan_lines = 3'b001;
                plan_cyc   = t_iss + TMO + 1;
            end
            MODE_LATE: begin
                plan_lines = 3'b001;
                plan_cyc   = t_iss + TMO;
            end
            MODE_ERRACK: begin
                plan_lines = 3'b101;
                plan_cyc   = t_iss + 2;
            end
            default: begin
                plan_lines = 3'($urandom_range(0, 7));
                plan_cyc   = t_iss + int'($urandom_range(0, TMO + 2));
            end
        endcase
        // Verdict only counts inside the WAIT window t_iss+1 .. t_iss+TMO.
        if (plan_lines != 3'b000 && plan_cyc > t_iss && plan_cyc <= t_iss + TMO) begin
            rsp_cyc  = plan_cyc + 1;
            exp_code = plan_lines[2] ? 2'd2 : (plan_lines[1] ? 2'd1 : 2'd0);
        end else begin
            rsp_cyc  = t_iss + TMO + 1;
            exp_code = 2'd3;
        end
        end_cyc     = rsp_cyc + GAP;
        cur_word[i] = gen_word();
    endtask

    task automatic step();
        logic [NR-1:0] v;
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rsp;
        logic [2:0]    lines;
        bit            in_win;
        @(negedge clk);
        cyc++;
        if (act && cyc == end_cyc) begin
            act = 1'b0;
        end
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (remaining[i] > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
                v[i] = 1'b1;
            end
            req_data[32*i +: 32] = cur_word[i];
        end
        req_valid = v;
        in_win = act && cyc > t_iss && cyc < rsp_cyc;
        lines = (cyc == plan_cyc) ? plan_lines : 3'b000;
        if (mode == MODE_RAND && !in_win && $urandom_range(0, 7) == 0) begin
            lines = lines | 3'($urandom_range(1, 7));
        end
        {dec_err, dec_nak, dec_ack} = lines;
        #1;
        exp_ready = act ? '0 : rr_pick(v);
        exp_rsp   = (act && cyc == rsp_cyc) ? (NR'(1) << owner) : '0;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(act));
        check("dec_valid", 32'(dec_valid), 32'(act && cyc == t_iss));
        check("dec_data", dec_data, last_data);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        if (exp_rsp != '0) begin
            check("rsp_code", 32'(rsp_code), 32'(exp_code));
        end
        for (int i = 0; i < NR; i++) begin
            if (rsp_valid[i]) begin
                rsp_cnt[i]++;
            end
        end
        if (exp_ready != '0) begin
            start_txn(first_one(exp_ready));
        end
    endtask

    task automatic setup(input int m, input int pct, input int r, input bit ff);
        mode      = m;
        valid_pct = pct;
        force_ff  = ff;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = r;
            rsp_cnt[i]   = 0;
            cur_word[i]  = gen_word();
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
        check({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
        check({tag, "_dec_data"}, dec_data, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Power-on reset with a requester already asserting valid.
        req_valid = '1;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        req_valid = '0;
        reset_n   = 1'b1;

        // Single word from requester 0, standard decoder acks.
        setup(MODE_STD, 100, 0, 1'b0);
        remaining[0] = 1;
        cur_word[0]  = 32'h0500ABCD;
        run(10);
        check("single_rsp_cnt0", 32'(rsp_cnt[0]), 32'd1);

        // Both requesters continuously valid, six words each.
        setup(MODE_STD, 100, 6, 1'b0);
        run(90);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("rr_rsp_cnt%0d", i), 32'(rsp_cnt[i]), 32'd6);
        end

        // Unknown code 0xFF: decoder naks one cycle later.
        setup(MODE_STD, 100, 0, 1'b1);
        remaining[0] = 2;
        run(20);
        check("nak_rsp_cnt0", 32'(rsp_cnt[0]), 32'd2);

        // Silent decoder: timeout, stray ack lands in GAP.
        setup(MODE_SILENT, 100, 1, 1'b0);
        run(45);
        check("tmo_rsp_cnt1", 32'(rsp_cnt[1]), 32'd1);

        // Ack in the last WAIT cycle beats the timeout.
        setup(MODE_LATE, 100, 0, 1'b0);
        remaining[0] = 1;
        run(22);

        // err and ack together.
        setup(MODE_ERRACK, 100, 1, 1'b0);
        run(16);

        // Reset during WAIT: move pointer to 1 first, then drop the transaction.
        setup(MODE_SILENT, 100, 0, 1'b0);
        remaining[0] = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (act && cyc >= t_iss + 2) begin
                break;
            end
        end
        check("reset_in_wait_reached", 32'(act && cyc >= t_iss + 2), 32'd1);
        #2;
        req_valid = '1;
        reset_n   = 1'b0;
        #1;
        check_all_zero("midrst");
        act        = 1'b0;
        ptr        = 0;
        last_data  = '0;
        exp_code   = 2'd0;
        plan_cyc   = -100;
        plan_lines = 3'b000;
        req_valid  = '0;
        repeat (2) @(negedge clk);
        cyc += 2;
        reset_n = 1'b1;
        setup(MODE_STD, 100, 1, 1'b0);
        run(20);
        check("post_rst_cnt0", 32'(rsp_cnt[0]), 32'd1);

        // Randomised traffic, verdicts, delays and stray pulses.
        setup(MODE_RAND, 60, 40, 1'b0);
        run(1200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
